// File: rtl/regfile_fifo_bridge.sv
// Software-driven FIFO fed by AXI register-file slots: toggle bits in ctrl_reg push/pop words,
// results loop back as a popped-data word and a status word.
module regfile_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          axi_aclk,
  input  logic          reset,
  input  logic [31:0]   ctrl_reg,
  input  logic [DW-1:0] wdata_reg,
  output logic [DW-1:0] rdata,
  output logic [31:0]   status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_ovf;
  logic          r_udf;
  logic          r_armed;
  logic [1:0]    r_ctrl_q;
  logic [DW-1:0] r_rdata;

  logic          w_clear;
  logic          w_push_req;
  logic          w_pop_req;
  logic          w_do_push;
  logic          w_do_pop;
  logic [LW-1:0] w_level_nxt;
  logic          w_unused_ctrl;

  assign w_unused_ctrl = ^ctrl_reg[31:3];

  // A toggle bit differing from its previous sample is one request; nothing fires until armed.
  always_comb begin
    w_clear     = ctrl_reg[2];
    w_push_req  = r_armed && !w_clear && (ctrl_reg[0] ^ r_ctrl_q[0]);
    w_pop_req   = r_armed && !w_clear && (ctrl_reg[1] ^ r_ctrl_q[1]);
    w_do_pop    = w_pop_req && !r_empty;
    w_do_push   = w_push_req && (!r_full || w_do_pop);
    w_level_nxt = r_level + LW'(w_do_push) - LW'(w_do_pop);
  end

  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_armed  <= 1'b0;
      r_ctrl_q <= 2'b00;
      r_rdata  <= '0;
    end else begin
      r_armed  <= 1'b1;
      r_ctrl_q <= ctrl_reg[1:0];
      if (w_clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
        r_empty <= 1'b1;
        r_full  <= 1'b0;
        r_ovf   <= 1'b0;
        r_udf   <= 1'b0;
      end else begin
        if (w_do_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_do_pop) begin
          r_rptr  <= r_rptr + AW'(1);
          r_rdata <= r_mem[r_rptr];
        end
        if (w_push_req && !w_do_push) begin
          r_ovf <= 1'b1;
        end
        if (w_pop_req && !w_do_pop) begin
          r_udf <= 1'b1;
        end
        r_level <= w_level_nxt;
        r_empty <= (w_level_nxt == '0);
        r_full  <= (w_level_nxt == FULL_LVL);
      end
    end
  end

  // Storage is never reset; pointers alone define which entries are valid.
  always_ff @(posedge axi_aclk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata_reg;
    end
  end

  assign rdata  = r_rdata;
  assign status = {12'b0, r_udf, r_ovf, r_full, r_empty, 16'(r_level)};

endmodule
